// File: rtl/cluster_tx_scheduler_if.sv
// Bus between the cluster scheduler (slave) and its controller/sink (master).
// DEPTH must match the scheduler instance so that fill_level has the same width.
interface cluster_tx_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          enable;
  logic          bx_strobe;
  logic [111:0]  cluster_in;
  logic          tx_ready;
  logic          tx_valid;
  logic [13:0]   tx_cluster;
  logic          tx_first;
  logic          reverse_priority_order;
  logic          truncate_clusters;
  logic [FW-1:0] fill_level;
  logic [15:0]   overflow_cnt;
  logic [1:0]    state;

  modport master (
    output enable, bx_strobe, cluster_in, tx_ready,
    input  tx_valid, tx_cluster, tx_first, reverse_priority_order,
           truncate_clusters, fill_level, overflow_cnt, state
  );

  modport slave (
    input  enable, bx_strobe, cluster_in, tx_ready,
    output tx_valid, tx_cluster, tx_first, reverse_priority_order,
           truncate_clusters, fill_level, overflow_cnt, state
  );
endinterface

// File: rtl/cluster_tx_scheduler.sv
// Compacts the valid clusters of each bunch crossing into a FIFO and streams
// them out one per clock4x cycle, with occupancy backpressure and drop counting.
module cluster_tx_scheduler #(
  parameter int DEPTH              = 16,
  parameter int AFULL_THRESH       = 12,
  parameter int ALTERNATE_PRIORITY = 1
) (
  input  logic                  clock4x,
  input  logic                  global_reset_n,
  cluster_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [FW-1:0] SET_LVL   = FW'(AFULL_THRESH);
  localparam logic [FW-1:0] CLR_LVL   = FW'(AFULL_THRESH - 4);
  localparam logic [FW-1:0] DEPTH_LVL = FW'(DEPTH);

  logic [14:0]   mem_q [DEPTH];
  logic [14:0]   mem_d [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [13:0]   headCluster_q, headCluster_d;
  logic          headFirst_q, headFirst_d;
  logic          rev_q, rev_d;
  logic          trunc_q, trunc_d;
  logic [1:0]    state_q, state_d;

  logic          accept;
  logic          pop;
  logic [7:0]    clValid;
  logic [FW-1:0] freeSlots;
  logic [FW-1:0] nValid;
  logic [FW-1:0] nWritten;
  logic [16:0]   ovfSum;
  logic [14:0]   headWord;

  // Addresses above 1535 are the packer's empty marker; admission stops once
  // the space free at the start of the cycle is used up (lowest k wins).
  always_comb begin
    mem_d     = mem_q;
    clValid   = '0;
    nValid    = '0;
    nWritten  = '0;
    accept    = bus.bx_strobe && (state_q == RUN);
    freeSlots = DEPTH_LVL - fill_q;
    for (int k = 0; k < 8; k++) begin
      clValid[k] = accept && (bus.cluster_in[14*k +: 11] <= 11'd1535);
      if (clValid[k]) begin
        nValid = nValid + FW'(1);
        if (nWritten < freeSlots) begin
          mem_d[wrPtr_q + AW'(nWritten)] = {(nWritten == '0), bus.cluster_in[14*k +: 14]};
          nWritten = nWritten + FW'(1);
        end
      end
    end
  end

  always_comb begin
    pop     = (fill_q != '0) && bus.tx_ready;
    rdPtr_d = rdPtr_q + AW'(pop);
    wrPtr_d = wrPtr_q + AW'(nWritten);
    fill_d  = fill_q + nWritten - FW'(pop);
    ovfSum  = {1'b0, ovf_q} + 17'(nValid - nWritten);
    ovf_d   = ovfSum[16] ? 16'hFFFF : ovfSum[15:0];
  end

  // The head register looks through this cycle's writes so a cluster written
  // into an empty FIFO is visible on the very next cycle.
  always_comb begin
    headWord      = mem_d[rdPtr_d];
    headCluster_d = headCluster_q;
    headFirst_d   = headFirst_q;
    if (fill_d != '0) begin
      headCluster_d = headWord[13:0];
      headFirst_d   = headWord[14];
    end
  end

  always_comb begin
    trunc_d = trunc_q;
    if (fill_q >= SET_LVL) begin
      trunc_d = 1'b1;
    end else if (fill_q < CLR_LVL) begin
      trunc_d = 1'b0;
    end
    rev_d = (ALTERNATE_PRIORITY != 0) ? (rev_q ^ bus.bx_strobe) : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable)       state_d = RUN;
      RUN:     if (!bus.enable)      state_d = DRAIN;
      DRAIN:   if (fill_q == '0)     state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      fill_q        <= '0;
      ovf_q         <= '0;
      headCluster_q <= '0;
      headFirst_q   <= 1'b0;
      rev_q         <= 1'b0;
      trunc_q       <= 1'b0;
      state_q       <= IDLE;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      fill_q        <= fill_d;
      ovf_q         <= ovf_d;
      headCluster_q <= headCluster_d;
      headFirst_q   <= headFirst_d;
      rev_q         <= rev_d;
      trunc_q       <= trunc_d;
      state_q       <= state_d;
    end
  end

  always_ff @(posedge clock4x) begin
    mem_q <= mem_d;
  end

  assign bus.tx_valid               = (fill_q != '0);
  assign bus.tx_cluster             = headCluster_q;
  assign bus.tx_first               = headFirst_q;
  assign bus.reverse_priority_order = rev_q;
  assign bus.truncate_clusters      = trunc_q;
  assign bus.fill_level             = fill_q;
  assign bus.overflow_cnt           = ovf_q;
  assign bus.state                  = state_q;
endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Directed bench for cluster_tx_scheduler: two instances, one with priority
// alternation enabled and one with it tied off, sharing the same stimulus.
module tb_cluster_tx_scheduler;
  localparam logic [111:0] EMPTY = {8{14'h07FF}};

  logic clock4x = 1'b0;
  logic global_reset_n;
  int   vecCount  = 0;
  int   missCount = 0;

  logic [111:0] cl;
  logic [13:0]  expWord  [16];
  logic         expFirst [16];

  always #5 clock4x = ~clock4x;

  cluster_tx_scheduler_if #(.DEPTH(16)) bus ();
  cluster_tx_scheduler_if #(.DEPTH(16)) busFixed ();

  cluster_tx_scheduler #(
    .DEPTH(16), .AFULL_THRESH(12), .ALTERNATE_PRIORITY(1)
  ) dut (
    .clock4x(clock4x), .global_reset_n(global_reset_n), .bus(bus)
  );

  cluster_tx_scheduler #(
    .DEPTH(16), .AFULL_THRESH(12), .ALTERNATE_PRIORITY(0)
  ) dutFixed (
    .clock4x(clock4x), .global_reset_n(global_reset_n), .bus(busFixed)
  );

  assign busFixed.enable     = bus.enable;
  assign busFixed.bx_strobe  = bus.bx_strobe;
  assign busFixed.cluster_in = bus.cluster_in;
  assign busFixed.tx_ready   = bus.tx_ready;

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One strobe cycle carrying the given crossing.
  task automatic applyStimulus(input logic [111:0] clusters);
    bus.bx_strobe  = 1'b1;
    bus.cluster_in = clusters;
    tick();
    bus.bx_strobe  = 1'b0;
    bus.cluster_in = EMPTY;
  endtask

  function automatic logic [111:0] seqClusters(input int base);
    logic [111:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[14*k +: 14] = 14'(base + k);
    return v;
  endfunction

  initial begin
    global_reset_n = 1'b0;
    bus.enable     = 1'b0;
    bus.bx_strobe  = 1'b0;
    bus.cluster_in = EMPTY;
    bus.tx_ready   = 1'b0;
    #3;
    checkOutput("rst_fill",  32'(bus.fill_level), 0);
    checkOutput("rst_valid", 32'(bus.tx_valid), 0);
    checkOutput("rst_ovf",   32'(bus.overflow_cnt), 0);
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_trunc", 32'(bus.truncate_clusters), 0);
    checkOutput("rst_rev",   32'(bus.reverse_priority_order), 0);
    #3;
    global_reset_n = 1'b1;

    // Single cluster through an empty FIFO
    bus.enable   = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    checkOutput("t1_state_run", 32'(bus.state), 1);
    cl = EMPTY;
    cl[13:0] = 14'h1005;
    applyStimulus(cl);
    checkOutput("t1_valid",   32'(bus.tx_valid), 1);
    checkOutput("t1_cluster", 32'(bus.tx_cluster), 32'h1005);
    checkOutput("t1_first",   32'(bus.tx_first), 1);
    checkOutput("t1_fill",    32'(bus.fill_level), 1);
    checkOutput("t1_rev",     32'(bus.reverse_priority_order), 1);
    tick();
    checkOutput("t1_valid_after", 32'(bus.tx_valid), 0);
    checkOutput("t1_fill_after",  32'(bus.fill_level), 0);

    // Full crossing drains in address order
    applyStimulus(seqClusters(0));
    checkOutput("t2_fill_peak", 32'(bus.fill_level), 8);
    checkOutput("t2_rev",       32'(bus.reverse_priority_order), 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_valid",   32'(bus.tx_valid), 1);
      checkOutput("t2_cluster", 32'(bus.tx_cluster), 32'(i));
      checkOutput("t2_first",   32'(bus.tx_first), 32'(i == 0));
      tick();
    end
    checkOutput("t2_fill_end", 32'(bus.fill_level), 0);

    // Overflow, truncate and priority alternation
    bus.tx_ready = 1'b0;
    applyStimulus(seqClusters(16));
    checkOutput("t3_fill_a",  32'(bus.fill_level), 8);
    checkOutput("t3_trunc_a", 32'(bus.truncate_clusters), 0);
    checkOutput("t3_rev_a",   32'(bus.reverse_priority_order), 1);
    checkOutput("t3_revfix_a", 32'(busFixed.reverse_priority_order), 0);
    applyStimulus(seqClusters(32));
    checkOutput("t3_fill_b",  32'(bus.fill_level), 16);
    checkOutput("t3_trunc_b", 32'(bus.truncate_clusters), 0);
    checkOutput("t3_ovf_b",   32'(bus.overflow_cnt), 0);
    checkOutput("t3_rev_b",   32'(bus.reverse_priority_order), 0);
    checkOutput("t3_revfix_b", 32'(busFixed.reverse_priority_order), 0);
    applyStimulus(seqClusters(48));
    checkOutput("t3_fill_c",  32'(bus.fill_level), 16);
    checkOutput("t3_ovf_c",   32'(bus.overflow_cnt), 8);
    checkOutput("t3_trunc_c", 32'(bus.truncate_clusters), 1);
    checkOutput("t3_rev_c",   32'(bus.reverse_priority_order), 1);
    checkOutput("t3_revfix_c", 32'(busFixed.reverse_priority_order), 0);

    // Back-to-back strobes into a full FIFO until the drop counter saturates
    bus.bx_strobe  = 1'b1;
    bus.cluster_in = seqClusters(64);
    repeat (8200) tick();
    bus.bx_strobe  = 1'b0;
    bus.cluster_in = EMPTY;
    checkOutput("t3_ovf_sat",  32'(bus.overflow_cnt), 32'hFFFF);
    checkOutput("t3_fill_sat", 32'(bus.fill_level), 16);
    checkOutput("t3_head_sat", 32'(bus.tx_cluster), 16);
    applyStimulus(seqClusters(64));
    checkOutput("t3_ovf_hold", 32'(bus.overflow_cnt), 32'hFFFF);

    // Hysteresis on the way down: clears one cycle after fill reaches 7
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput("t4_fill",    32'(bus.fill_level), 32'(16 - i));
      checkOutput("t4_trunc",   32'(bus.truncate_clusters), 32'(i < 10));
      checkOutput("t4_cluster", 32'(bus.tx_cluster), (i < 8) ? 32'(16 + i) : 32'(24 + i));
    end
    repeat (6) tick();
    checkOutput("t4_fill_end", 32'(bus.fill_level), 0);

    // Set threshold exactly at 12
    bus.tx_ready = 1'b0;
    applyStimulus(seqClusters(80));
    cl = EMPTY;
    cl[41:0] = {14'd92, 14'd91, 14'd90};
    applyStimulus(cl);
    checkOutput("th_fill11", 32'(bus.fill_level), 11);
    tick();
    checkOutput("th_trunc11", 32'(bus.truncate_clusters), 0);
    cl = EMPTY;
    cl[13:0] = 14'd93;
    applyStimulus(cl);
    checkOutput("th_fill12",  32'(bus.fill_level), 12);
    checkOutput("th_trunc_pre", 32'(bus.truncate_clusters), 0);
    tick();
    checkOutput("th_trunc12", 32'(bus.truncate_clusters), 1);
    bus.tx_ready = 1'b1;
    repeat (7) tick();
    checkOutput("th_fill5",  32'(bus.fill_level), 5);
    checkOutput("th_trunc5", 32'(bus.truncate_clusters), 0);

    // Drain: strobes and enable are ignored until IDLE
    bus.tx_ready = 1'b0;
    bus.enable   = 1'b0;
    tick();
    checkOutput("t6_state_drain", 32'(bus.state), 2);
    checkOutput("t6_fill5",       32'(bus.fill_level), 5);
    applyStimulus(seqClusters(100));
    checkOutput("t6_fill_ignore", 32'(bus.fill_level), 5);
    checkOutput("t6_ovf_ignore",  32'(bus.overflow_cnt), 32'hFFFF);
    bus.enable   = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (5) tick();
    checkOutput("t6_fill0",      32'(bus.fill_level), 0);
    checkOutput("t6_still_drain", 32'(bus.state), 2);
    tick();
    checkOutput("t6_state_idle", 32'(bus.state), 0);
    tick();
    checkOutput("t6_state_run",  32'(bus.state), 1);

    // Asynchronous reset in the middle of a drain
    bus.tx_ready = 1'b0;
    applyStimulus(seqClusters(110));
    bus.enable = 1'b0;
    tick();
    checkOutput("t6b_state_drain", 32'(bus.state), 2);
    bus.tx_ready = 1'b1;
    tick();
    checkOutput("t6b_fill7", 32'(bus.fill_level), 7);
    #2;
    global_reset_n = 1'b0;
    #1;
    checkOutput("t6b_fill",    32'(bus.fill_level), 0);
    checkOutput("t6b_valid",   32'(bus.tx_valid), 0);
    checkOutput("t6b_cluster", 32'(bus.tx_cluster), 0);
    checkOutput("t6b_first",   32'(bus.tx_first), 0);
    checkOutput("t6b_ovf",     32'(bus.overflow_cnt), 0);
    checkOutput("t6b_trunc",   32'(bus.truncate_clusters), 0);
    checkOutput("t6b_rev",     32'(bus.reverse_priority_order), 0);
    checkOutput("t6b_state",   32'(bus.state), 0);
    #1;
    global_reset_n = 1'b1;

    // Compaction across empties, the 1535/1536 boundary and partial admission
    bus.enable   = 1'b1;
    bus.tx_ready = 1'b0;
    tick();
    checkOutput("pa_state_run", 32'(bus.state), 1);
    applyStimulus(seqClusters(0));
    cl = {14'h3DFF, 14'd53, 14'h2E00, 14'd52, 14'd51, 14'h07FF, 14'd50, 14'h0600};
    applyStimulus(cl);
    checkOutput("pa_fill13", 32'(bus.fill_level), 13);
    applyStimulus(seqClusters(200));
    checkOutput("pa_fill16", 32'(bus.fill_level), 16);
    checkOutput("pa_ovf5",   32'(bus.overflow_cnt), 5);
    for (int i = 0; i < 8; i++) begin
      expWord[i]  = 14'(i);
      expFirst[i] = (i == 0);
    end
    expWord[8]  = 14'd50;   expFirst[8]  = 1'b1;
    expWord[9]  = 14'd51;   expFirst[9]  = 1'b0;
    expWord[10] = 14'd52;   expFirst[10] = 1'b0;
    expWord[11] = 14'd53;   expFirst[11] = 1'b0;
    expWord[12] = 14'h3DFF; expFirst[12] = 1'b0;
    expWord[13] = 14'd200;  expFirst[13] = 1'b1;
    expWord[14] = 14'd201;  expFirst[14] = 1'b0;
    expWord[15] = 14'd202;  expFirst[15] = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("pa_valid",   32'(bus.tx_valid), 1);
      checkOutput("pa_cluster", 32'(bus.tx_cluster), 32'(expWord[i]));
      checkOutput("pa_first",   32'(bus.tx_first), 32'(expFirst[i]));
      tick();
    end
    checkOutput("pa_fill_end",  32'(bus.fill_level), 0);
    checkOutput("pa_valid_end", 32'(bus.tx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule

// File: doc/cluster_tx_scheduler.md
Name: cluster_tx_scheduler

Overview:
Sequences the 8-cluster output of cluster_packer onto a single ready/valid cluster stream. It runs on clock4x and compacts the valid clusters of each bunch crossing into a FIFO. It drives the packer's reverse_priority_order control, alternating each crossing for fairness, and drives truncate_clusters as occupancy backpressure. Dropped clusters are counted.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 8.
AFULL_THRESH, 12, fill level at which truncate_clusters asserts; must be 4..DEPTH.
ALTERNATE_PRIORITY, 1, 1 = toggle reverse_priority_order each crossing; 0 = tie it to 0.

Ports:
clock4x  in  1  sole clock.
global_reset_n  in  1  asynchronous, active-low reset.
enable  in  1  1 = accept clusters.
bx_strobe  in  1  one-cycle pulse; cluster_in is valid on this cycle.
cluster_in  in  112  cluster k at [14k+13:14k], k = 0..7; {cnt[2:0], adr[10:0]}.
tx_ready  in  1  sink accepts the head entry.
tx_valid  out  1  head entry is valid.
tx_cluster  out  14  head cluster.
tx_first  out  1  head is the first stored cluster of its crossing.
reverse_priority_order  out  1  to packer.
truncate_clusters  out  1  to packer.
fill_level  out  log2(DEPTH)+1  stored entry count.
overflow_cnt  out  16  dropped clusters, saturating at 0xFFFF.
state  out  2  0 = IDLE, 1 = RUN, 2 = DRAIN.

Behaviour:
- Reset (asynchronous assert, applies immediately, including mid-operation): FIFO pointers, fill_level, overflow_cnt, tx_cluster, tx_valid, tx_first, reverse_priority_order and truncate_clusters all go to 0. state goes to IDLE.
- Valid cluster: adr <= 1535. adr 1536..2047 is treated as empty (the packer emits 0x7FF for empty) and is ignored.
- State machine:
  - IDLE -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0.
  - DRAIN -> IDLE when fill_level = 0 and no read is pending.
  - enable is not sampled in DRAIN; a reasserted enable takes effect only from IDLE.
- Writes occur only in RUN, on bx_strobe. Up to 8 valid clusters are written in one cycle.
  - Order: ascending index k, compacted with no gaps.
  - Each entry stores a 15-bit word {first, cluster}; first = 1 only on the lowest-k valid cluster of that strobe.
- Admission:
  - free = DEPTH - fill_level, taken at the start of the cycle; a same-cycle read does not add space.
  - If n_valid > free, the lowest-k free clusters are written and the rest are dropped.
  - overflow_cnt += dropped, saturating.
  - Strobes outside RUN write nothing and count nothing.
- Read: pop when tx_valid & tx_ready. tx_valid = (fill_level != 0).
  - tx_cluster and tx_first are the head entry, a registered FIFO output.
  - Write-to-visible latency is 1 cycle when the FIFO is empty.
  - fill_level(next) = fill_level + written - popped.
  - Simultaneous write and pop is legal.
- Throughput: 1 cluster per clock4x cycle, i.e. 4 per crossing at the nominal 1-in-4 strobe rate. Sustained input above 4 valid clusters per crossing fills the FIFO.
- truncate_clusters is registered from fill_level:
  - sets the cycle after fill_level >= AFULL_THRESH;
  - clears the cycle after fill_level < AFULL_THRESH-4;
  - holds its value otherwise (hysteresis).
- reverse_priority_order:
  - with ALTERNATE_PRIORITY = 1, it toggles on the cycle after every bx_strobe, in all states;
  - with ALTERNATE_PRIORITY = 0, it is constant 0.
  - The strobe's own clusters are taken as presented; the packer's priority is a pipeline-external concern.
- tx_cluster holds its last value when tx_valid = 0; its content is don't-care to the sink.
- A bx_strobe asserted on consecutive cycles is legal: each pulse is processed independently.

Test Plan:
1. Single cluster. Reset, enable = 1, tx_ready = 1. Strobe with cluster0 = 0x1005 and clusters 1..7 = 0x07FF.
   -> Next cycle: tx_valid = 1, tx_cluster = 0x1005, tx_first = 1. The cycle after: tx_valid = 0, fill_level = 0.
2. Full crossing. Strobe with all 8 clusters valid (adr 0..7), tx_ready = 1.
   -> 8 consecutive pops in adr order 0..7; tx_first = 1 only on adr 0; fill_level peaks at 8.
3. Overflow and truncate. tx_ready = 0; three strobes of 8 valid clusters each.
   -> fill_level = 16; overflow_cnt = 8; truncate_clusters = 1 from the cycle after fill_level first reaches 12.
   -> Saturation: force overflow_cnt to 0xFFFF, drop further -> holds at 0xFFFF.
4. Hysteresis. From fill 16 with truncate = 1, set tx_ready = 1.
   -> truncate stays 1 through fill 8; clears the cycle after fill_level = 7.
5. Priority toggle. Three strobes with ALTERNATE_PRIORITY = 1.
   -> reverse_priority_order = 1, 0, 1 after successive strobes. With the parameter = 0, it stays 0.
6. Drain and reset. fill_level = 5, drop enable.
   -> state = DRAIN; a strobe during DRAIN is ignored (overflow_cnt unchanged); 5 pops, then state = IDLE.
   -> Repeat, and assert global_reset_n = 0 mid-drain -> all outputs 0 and state = IDLE immediately, without waiting for a clock.
